ram_burst_reader: RTL

Read-side initiator for the single-port synchronous-read RAMs (`ram_sync_read_*` family). It accepts a burst request (start address, length) and drives the RAM address port, one address per cycle. It absorbs the RAM's one-cycle read latency and returns the words as a valid/ready stream with `last` marking. It sits between a RAM instance and any consumer that needs back-pressured sequential reads.

---
 rtl/ram_rd_pkg.sv | 12 +
 rtl/ram_rd_skid_fifo.sv | 44 ++++
 rtl/ram_burst_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM burst reader: read-FSM state encoding and output FIFO depth.
package ram_rd_pkg;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry FIFO that holds returning RAM words ({last, data}) until the consumer takes them.
// The head entry stays unchanged until it is popped. Push and pop in the same cycle are both allowed.
module ram_rd_skid_fifo
  import ram_rd_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  // Each pointer is a single bit because the FIFO has exactly two entries.
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a synchronous-read RAM. It absorbs the 1-cycle read latency and returns a valid/ready stream.
// Optional feature: define RAM_BURST_READER_WRAP_EN to wrap bursts past the top of memory instead of truncating them.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [AWIDTH:0]   req_len,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output rd_state_t         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // A valid source holds its payload unchanged until that transfer; ready may change freely.

  localparam logic [AWIDTH:0] DEPTH_L = {1'b1, {AWIDTH{1'b0}}};

  rd_state_t       state;
  logic [AWIDTH:0] remaining;
  logic [AWIDTH:0] eff_len;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      fifo_count;
  logic            pop;
  logic            issue;
  logic [2:0]      credit_used;

`ifdef RAM_BURST_READER_WRAP_EN
  always_comb begin
    eff_len = req_len;
    if (req_len > DEPTH_L) eff_len = DEPTH_L;
  end
`else
  logic [AWIDTH:0] room;
  always_comb begin
    room    = DEPTH_L - {1'b0, req_addr};
    eff_len = req_len;
    if (req_len > room) eff_len = room;
  end
`endif

  assign pop = out_valid & out_ready;

  // Credits count words that will still occupy the FIFO after this edge, including the in-flight word.
  // Counting the pop in the same cycle lets the reader sustain one word per cycle under no back-pressure.
  assign credit_used = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue       = (state == ISSUE) && (credit_used < 3'(FIFO_DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ram_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == (AWIDTH+1)'(1));
      case (state)
        IDLE: begin
          if (req_valid && eff_len != '0) begin
            ram_addr  <= req_addr;
            remaining <= eff_len;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            remaining <= remaining - (AWIDTH+1)'(1);
            // After the final issue, ram_addr keeps the last address it drove.
            if (remaining == (AWIDTH+1)'(1)) state <= DRAIN;
            else                             ram_addr <= ram_addr + AWIDTH'(1);
          end
        end
        DRAIN: begin
          if (credit_used == 3'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_rd_skid_fifo #(
    .WIDTH (DWIDTH + 1)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (inflight),
    .pop     (pop),
    .wr_data ({inflight_last, ram_dout}),
    .rd_data ({out_last, out_data}),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign ram_we    = 1'b0;
  assign dbg_state = state;

endmodule
